// File: rtl/imem_dbg_pkg.sv
// Shared types, widths and helpers for the instruction-RAM debug sequencer.
package imem_dbg_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned TMR_W  = 16;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StWrite,
      StRead,
      StCapture,
      StResp,
      StHold
   } state_e;

   typedef enum logic [1:0] {
      ErrNone,
      ErrAlign,
      ErrZeroBe,
      ErrVerify
   } err_e;

   // Expand byte enables into a per-bit compare mask.
   function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < BE_W; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   function automatic err_e cmd_check(input logic write, input logic [1:0] addr_lsb,
                                      input logic [BE_W-1:0] be);
      if (addr_lsb != 2'b00) return ErrAlign;
      if (write && (be == '0)) return ErrZeroBe;
      return ErrNone;
   endfunction

endpackage

// File: rtl/dbg_timer.sv
// Loadable down-counter shared by the drain delay and the halted-state timeout.
module dbg_timer
   import imem_dbg_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [TMR_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/imem_debug_ctrl.sv
// Debug-host sequencer for the instruction RAM debug port: halts the pipeline, performs one
// read or (optionally verified) write, and flushes the front end on release after a write.
module imem_debug_ctrl
   import imem_dbg_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned HOLD_TIMEOUT = 64,
   parameter int unsigned VERIFY       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [DATA_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [BE_W-1:0]   cmd_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic              release_req,
   output logic              cpu_halt,
   output logic              cpu_flush,
   output logic [DATA_W-1:0] A2,
   output logic [DATA_W-1:0] WD2,
   output logic [BE_W-1:0]   WE2,
   input  logic [DATA_W-1:0] RD2
);

   state_e            state_d, state_q;
   logic              write_d, write_q;
   logic [DATA_W-1:0] addr_d, addr_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic [BE_W-1:0]   be_d, be_q;
   logic              dirty_d, dirty_q;
   logic [DATA_W-1:0] a2_d, a2_q;
   logic [DATA_W-1:0] wd2_d, wd2_q;
   logic [BE_W-1:0]   we2_d, we2_q;
   logic              halt_d, halt_q;
   logic              flush_d, flush_q;
   logic              rsp_valid_d, rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
   err_e              err_d, err_q;

   logic              tmr_load, tmr_dec, tmr_zero;
   logic [TMR_W-1:0]  tmr_val;
   logic              accept, leave, go_op;
   err_e              cmd_err;
   logic              op_write;
   logic [DATA_W-1:0] op_addr, op_wdata;
   logic [BE_W-1:0]   op_be;

   dbg_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   // Release (host or timeout) beats a simultaneous command in the halted state.
   assign leave     = release_req || tmr_zero;
   assign cmd_ready = (state_q == StIdle) || ((state_q == StHold) && !leave);
   assign accept    = cmd_valid && cmd_ready;
   assign cmd_err   = cmd_check(cmd_write, cmd_addr[1:0], cmd_be);

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      dirty_d     = dirty_q;
      a2_d        = '0;
      wd2_d       = '0;
      we2_d       = '0;
      halt_d      = halt_q;
      flush_d     = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      err_d       = err_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      tmr_dec     = 1'b0;
      go_op       = 1'b0;

      // After a drain the latched command is used; otherwise the live command bus.
      if (state_q == StDrain) begin
         op_write = write_q;
         op_addr  = addr_q;
         op_wdata = wdata_q;
         op_be    = be_q;
      end else begin
         op_write = cmd_write;
         op_addr  = cmd_addr;
         op_wdata = cmd_wdata;
         op_be    = cmd_be;
      end

      if (accept) begin
         write_d = cmd_write;
         addr_d  = cmd_addr;
         wdata_d = cmd_wdata;
         be_d    = cmd_be;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (cmd_err != ErrNone) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  err_d       = cmd_err;
               end else begin
                  halt_d = 1'b1;
                  if (DRAIN_CYCLES == 0) begin
                     go_op = 1'b1;
                  end else begin
                     state_d  = StDrain;
                     tmr_load = 1'b1;
                     tmr_val  = TMR_W'(DRAIN_CYCLES - 1);
                  end
               end
            end
         end
         StDrain: begin
            if (tmr_zero) begin
               go_op = 1'b1;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         StWrite: begin
            dirty_d = 1'b1;
            if (VERIFY != 0) begin
               state_d = StRead;
               a2_d    = addr_q;
            end else begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               err_d       = ErrNone;
            end
         end
         StRead: begin
            state_d = StCapture;
         end
         StCapture: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = RD2;
            if (write_q && (((RD2 ^ wdata_q) & be_mask(be_q)) != '0)) begin
               err_d = ErrVerify;
            end else begin
               err_d = ErrNone;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               err_d       = ErrNone;
               if (halt_q) begin
                  state_d  = StHold;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(HOLD_TIMEOUT - 1);
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StHold: begin
            if (leave) begin
               state_d = StIdle;
               halt_d  = 1'b0;
               flush_d = dirty_q;
               dirty_d = 1'b0;
            end else if (accept) begin
               if (cmd_err != ErrNone) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  err_d       = cmd_err;
               end else begin
                  go_op = 1'b1;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (go_op) begin
         state_d = op_write ? StWrite : StRead;
         a2_d    = op_addr;
         wd2_d   = op_write ? op_wdata : '0;
         we2_d   = op_write ? op_be : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         dirty_q     <= 1'b0;
         a2_q        <= '0;
         wd2_q       <= '0;
         we2_q       <= '0;
         halt_q      <= 1'b0;
         flush_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         err_q       <= ErrNone;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         dirty_q     <= dirty_d;
         a2_q        <= a2_d;
         wd2_q       <= wd2_d;
         we2_q       <= we2_d;
         halt_q      <= halt_d;
         flush_q     <= flush_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         err_q       <= err_d;
      end
   end

   assign A2        = a2_q;
   assign WD2       = wd2_q;
   assign WE2       = we2_q;
   assign cpu_halt  = halt_q;
   assign cpu_flush = flush_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = (err_q != ErrNone);

endmodule

// File: tb/tb_imem_debug_ctrl.sv
// Directed bench for imem_debug_ctrl with a small registered instruction-RAM model.
module tb_imem_debug_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        release_req, cpu_halt, cpu_flush;
   logic [31:0] A2, WD2, RD2;
   logic [3:0]  WE2;

   logic [31:0] mem [0:63];
   bit          mem_loaded;
   logic        force_b0;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   imem_debug_ctrl #(
      .DRAIN_CYCLES (4),
      .HOLD_TIMEOUT (64),
      .VERIFY       (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_be      (cmd_be),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .release_req (release_req),
      .cpu_halt    (cpu_halt),
      .cpu_flush   (cpu_flush),
      .A2          (A2),
      .WD2         (WD2),
      .WE2         (WE2),
      .RD2         (RD2)
   );

   // RAM model: byte-masked write, registered read; force_b0 corrupts byte 0 of writes.
   always @(posedge clk) begin
      if (!rst_n) begin
         RD2 <= '0;
         if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[4] <= 32'h0050_0093;
            mem[8] <= 32'h1122_3344;
            mem_loaded <= 1'b1;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (WE2[b]) mem[A2[7:2]][8*b +: 8] <= (force_b0 && b == 0) ? 8'h00 : WD2[8*b +: 8];
         end
         RD2 <= mem[A2[7:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   // Issue one command at posedge+1, wait for its response, record what was seen, handshake.
   task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat, output logic halt1, output int we_cyc,
                         output logic [3:0] we_val);
      rdata = '0; err = 1'b0; lat = 0; halt1 = 1'b0; we_cyc = 0; we_val = '0;
      check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_be = be;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      halt1 = cpu_halt;
      for (int i = 1; i <= 50; i++) begin
         if (WE2 != 4'h0) begin
            we_cyc++;
            we_val = WE2;
         end
         if (rsp_valid) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat == 0) begin
         total_cnt++;
         $display("FAIL rsp_timeout: no rsp_valid within 50 cycles of addr %h", a);
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      check("cmd_ready_while_busy", {31'd0, cmd_ready}, 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_valid_after_handshake", {31'd0, rsp_valid}, 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic        exp_halt;
      logic [3:0]  exp_we;
   } vec_t;

   vec_t        vecs [5];
   logic [31:0] g_rdata;
   logic        g_err, g_halt1;
   int          g_lat, g_wecyc, n;
   logic [3:0]  g_weval;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_be = '0; rsp_ready = 1'b0; release_req = 1'b0; force_b0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
      check("rst_cpu_flush", {31'd0, cpu_flush}, 32'd0);
      check("rst_we2", {28'd0, WE2}, 32'd0);
      check("rst_a2", A2, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First from IDLE, the rest from HOLD.
      vecs[0] = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h0050_0093, 1'b0, 7, 1'b1, 4'h0};
      vecs[1] = '{1'b1, 32'h20, 32'hDEAD_BEEF, 4'h3, 32'h1122_BEEF, 1'b0, 4, 1'b1, 4'h3};
      vecs[2] = '{1'b0, 32'h20, 32'h0,         4'h0, 32'h1122_BEEF, 1'b0, 3, 1'b1, 4'h0};
      vecs[3] = '{1'b0, 32'h22, 32'h0,         4'h0, 32'h0,         1'b1, 1, 1'b1, 4'h0};
      vecs[4] = '{1'b1, 32'h24, 32'h1234_5678, 4'h0, 32'h0,         1'b1, 1, 1'b1, 4'h0};
      for (int i = 0; i < 5; i++) begin
         do_cmd(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be,
                g_rdata, g_err, g_lat, g_halt1, g_wecyc, g_weval);
         check($sformatf("v%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d_err", i), {31'd0, g_err}, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d_latency", i), 32'(g_lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_halt_c1", i), {31'd0, g_halt1}, {31'd0, vecs[i].exp_halt});
         check($sformatf("v%0d_we_cycles", i), 32'(g_wecyc),
               (vecs[i].w && !vecs[i].exp_err) ? 32'd1 : 32'd0);
         check($sformatf("v%0d_we_value", i), {28'd0, g_weval}, {28'd0, vecs[i].exp_we});
      end

      // Timeout release after a write: 64 halted cycles, then a single flush pulse.
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (!cpu_halt) begin
            n = i;
            break;
         end
      end
      check("timeout_cycles", 32'(n), 32'd64);
      check("timeout_flush", {31'd0, cpu_flush}, 32'd1);
      @(posedge clk); #1;
      check("timeout_flush_pulse", {31'd0, cpu_flush}, 32'd0);

      // Misaligned from IDLE: immediate error, no halt, no write.
      do_cmd(1'b1, 32'h22, 32'hFFFF_FFFF, 4'hF, g_rdata, g_err, g_lat, g_halt1, g_wecyc, g_weval);
      check("idle_misal_err", {31'd0, g_err}, 32'd1);
      check("idle_misal_lat", 32'(g_lat), 32'd1);
      check("idle_misal_halt", {31'd0, g_halt1}, 32'd0);
      check("idle_misal_we", 32'(g_wecyc), 32'd0);
      check("idle_misal_halt_after", {31'd0, cpu_halt}, 32'd0);

      // Back-to-back reads, then release colliding with a command.
      do_cmd(1'b0, 32'h10, 32'h0, 4'h0, g_rdata, g_err, g_lat, g_halt1, g_wecyc, g_weval);
      check("b2b_rd1_lat", 32'(g_lat), 32'd7);
      do_cmd(1'b0, 32'h20, 32'h0, 4'h0, g_rdata, g_err, g_lat, g_halt1, g_wecyc, g_weval);
      check("b2b_rd2_lat", 32'(g_lat), 32'd3);
      check("b2b_rd2_rdata", g_rdata, 32'h1122_BEEF);
      release_req = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
      #1;
      check("release_blocks_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      release_req = 1'b0; cmd_valid = 1'b0;
      check("release_halt", {31'd0, cpu_halt}, 32'd0);
      check("release_no_flush", {31'd0, cpu_flush}, 32'd0);
      check("release_idle_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      check("release_no_cmd_taken", {31'd0, cpu_halt}, 32'd0);

      // Verify mismatch: RAM drops byte 0 of the write.
      force_b0 = 1'b1;
      do_cmd(1'b1, 32'h30, 32'h0000_00FF, 4'h1, g_rdata, g_err, g_lat, g_halt1, g_wecyc, g_weval);
      force_b0 = 1'b0;
      check("mismatch_err", {31'd0, g_err}, 32'd1);
      check("mismatch_lat", 32'(g_lat), 32'd8);
      check("mismatch_rdata", g_rdata, 32'h0);
      check("mismatch_we", {28'd0, g_weval}, 32'h1);
      release_req = 1'b1;
      @(posedge clk); #1;
      release_req = 1'b0;
      check("mismatch_release_flush", {31'd0, cpu_flush}, 32'd1);
      check("mismatch_release_halt", {31'd0, cpu_halt}, 32'd0);

      // Reset asserted during the write cycle.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h34; cmd_wdata = 32'hA5A5_A5A5;
      cmd_be = 4'hF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         if (WE2 != 4'h0) begin
            n = i;
            break;
         end
         @(posedge clk); #1;
      end
      check("rstw_write_cycle", 32'(n), 32'd5);
      rst_n = 1'b0;
      #1;
      check("rstw_we2_async", {28'd0, WE2}, 32'd0);
      check("rstw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rstw_cpu_halt", {31'd0, cpu_halt}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rstw_mem_untouched", mem[13], 32'h0);
      check("rstw_after_ready", {31'd0, cmd_ready}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
